// File: rtl/envelope_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : envelope_sequencer
// Brief   : Envelope tick generator and per-voice velocity sweep/write-back.
// Revision: 1.0 - initial release
// ============================================================================
module envelope_sequencer #(
    parameter int NUM_VOICES = 4,
    parameter int PULSE_DIV  = 1000,
    parameter int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_VOICES-1:0]     note_on,
    input  logic [6:0]                note_velocity,
    input  logic [NUM_VOICES-1:0]     key_held,
    input  logic                      sustain,
    input  logic [6:0]                new_velocity,
    output logic                      envelope_pulse,
    output logic                      poly_start,
    output logic [VW-1:0]             voice_idx,
    output logic [6:0]                velocity_sel,
    output logic                      key_pressed,
    output logic                      ended_note,
    output logic [7*NUM_VOICES-1:0]   voice_velocity,
    output logic [NUM_VOICES-1:0]     voice_active
);

    localparam int                    c_div_w      = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
    localparam logic [c_div_w-1:0]    c_div_last   = c_div_w'(PULSE_DIV - 1);
    localparam logic [VW-1:0]         c_last_voice = VW'(NUM_VOICES - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [VW-1:0]           r_sweep_idx, w_sweep_idx_nxt;
    logic [c_div_w-1:0]      r_div_cnt;

    logic [6:0]              r_vel [NUM_VOICES];
    logic [NUM_VOICES-1:0]   r_ended;
    logic [NUM_VOICES-1:0]   r_key_q;
    logic                    r_sus_q;

    logic                    w_sweeping;
    logic                    w_div_wrap;
    logic [6:0]              w_wb_vel;
    logic [NUM_VOICES-1:0]   w_swept;
    logic [NUM_VOICES-1:0]   w_set;

    assign w_div_wrap = (r_div_cnt == c_div_last);
    assign w_sweeping = (r_state == S_SWEEP);

    // Free-running time base; the sweep never stalls it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sweep_idx_nxt = r_sweep_idx;
        case (r_state)
            S_IDLE: begin
                if (w_div_wrap) begin
                    w_state_nxt     = S_SWEEP;
                    w_sweep_idx_nxt = '0;
                end
            end
            S_SWEEP: begin
                if (r_sweep_idx == c_last_voice) begin
                    w_state_nxt     = S_IDLE;
                    w_sweep_idx_nxt = '0;
                end else begin
                    w_sweep_idx_nxt = r_sweep_idx + VW'(1);
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_sweep_idx_nxt = '0;
            end
        endcase
    end

    assign envelope_pulse = w_sweeping;
    assign poly_start     = w_sweeping;
    assign voice_idx      = w_sweeping ? r_sweep_idx : '0;
    assign velocity_sel   = w_sweeping ? r_vel[r_sweep_idx] : 7'd0;
    assign key_pressed    = w_sweeping & key_held[r_sweep_idx];
    assign ended_note     = w_sweeping & r_ended[r_sweep_idx];

    // A result larger than the input means envelope_gen wrapped below zero.
    assign w_wb_vel = (new_velocity > velocity_sel) ? 7'd0 : new_velocity;

    always_comb begin
        w_swept = '0;
        w_set   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_swept[i] = w_sweeping && (r_sweep_idx == VW'(i));
            w_set[i]   = (r_vel[i] != 7'd0) &&
                         ((r_key_q[i] && !key_held[i] && !sustain) ||
                          (r_sus_q && !sustain && !key_held[i]));
        end
    end

    // Note-on beats write-back; a release beats the sweep clear so it is seen next sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_vel[i] <= 7'd0;
            end
            r_ended <= '0;
            r_key_q <= '0;
            r_sus_q <= 1'b0;
        end else begin
            r_key_q <= key_held;
            r_sus_q <= sustain;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (note_on[i]) begin
                    r_vel[i]   <= note_velocity;
                    r_ended[i] <= 1'b0;
                end else begin
                    if (w_swept[i]) begin
                        r_vel[i] <= w_wb_vel;
                    end
                    if (w_set[i]) begin
                        r_ended[i] <= 1'b1;
                    end else if (w_swept[i]) begin
                        r_ended[i] <= 1'b0;
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_flat
            assign voice_velocity[7*gi +: 7] = r_vel[gi];
            assign voice_active[gi]          = (r_vel[gi] != 7'd0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_envelope_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_envelope_sequencer
// Brief   : Table-driven bench with a queue scoreboard and envelope_gen model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_envelope_sequencer;

    localparam int c_nv = 4;
    localparam int c_pd = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [c_nv-1:0]   note_on = '0;
    logic [6:0]        note_velocity = '0;
    logic [c_nv-1:0]   key_held = '0;
    logic              sustain = 1'b0;
    logic [6:0]        new_velocity;
    logic              envelope_pulse;
    logic              poly_start;
    logic [1:0]        voice_idx;
    logic [6:0]        velocity_sel;
    logic              key_pressed;
    logic              ended_note;
    logic [7*c_nv-1:0] voice_velocity;
    logic [c_nv-1:0]   voice_active;
    logic [2:0]        pedal_depth = 3'd4;

    envelope_sequencer #(
        .NUM_VOICES (c_nv),
        .PULSE_DIV  (c_pd)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .note_on        (note_on),
        .note_velocity  (note_velocity),
        .key_held       (key_held),
        .sustain        (sustain),
        .new_velocity   (new_velocity),
        .envelope_pulse (envelope_pulse),
        .poly_start     (poly_start),
        .voice_idx      (voice_idx),
        .velocity_sel   (velocity_sel),
        .key_pressed    (key_pressed),
        .ended_note     (ended_note),
        .voice_velocity (voice_velocity),
        .voice_active   (voice_active)
    );

    always #5 clk = ~clk;

    // Behavioural envelope_gen: held key -1, ended -15, released 3*pedal_depth; wraps in 7 bits.
    function automatic logic [6:0] env_model(input logic [6:0] v, input logic kp,
                                             input logic en, input logic [2:0] pd);
        logic [6:0] dec;
        if (v == 7'd0) return 7'd0;
        if (kp)      dec = 7'd1;
        else if (en) dec = 7'd15;
        else         dec = 7'(3 * pd);
        return v - dec;
    endfunction

    assign new_velocity = env_model(velocity_sel, key_pressed, ended_note, pedal_depth);

    typedef struct {
        int         due;
        int         voice;
        logic [6:0] val;
    } exp_t;

    typedef struct {
        int         at;
        logic       do_rst;
        logic [3:0] non;
        logic [6:0] nvel;
        logic [3:0] key;
        logic       sus;
        int         chk_at;
        int         voice;
        int         exp_vel;
        int         en_exp;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[18];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         base     = 0;
    logic [6:0] m_vel [c_nv];
    logic [3:0] m_ended = '0;
    logic [3:0] pk = '0;
    logic       ps = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d after reset)", name, act, want, cyc - base);
        end
    endtask

    task automatic push_exp(input int voice, input logic [6:0] val);
        exp_t e;
        e.due   = cyc + 1;
        e.voice = voice;
        e.val   = val;
        sb_q.push_back(e);
    endtask

    // Called at a negedge with this cycle's inputs already driven.
    task automatic run_cycle();
        exp_t       e;
        int         pos;
        int         vi;
        logic       sw;
        logic [6:0] g;
        logic [3:0] set_v;
        logic [3:0] act_exp;
        #1;
        pos = cyc - base;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check($sformatf("scoreboard voice%0d velocity", e.voice),
                  voice_velocity[7*e.voice +: 7], e.val);
        end
        sw = (pos >= c_pd) && ((pos % c_pd) < c_nv);
        vi = (pos % c_pd) % c_nv;
        for (int i = 0; i < c_nv; i++) act_exp[i] = (m_vel[i] != 7'd0);
        check("envelope_pulse", envelope_pulse, sw);
        check("poly_start", poly_start, sw);
        check("voice_idx", voice_idx, sw ? vi : 0);
        check("velocity_sel", velocity_sel, sw ? m_vel[vi] : 7'd0);
        check("key_pressed", key_pressed, sw ? key_held[vi] : 1'b0);
        check("ended_note", ended_note, sw ? m_ended[vi] : 1'b0);
        check("voice_active", voice_active, act_exp);
        if (rst) begin
            for (int i = 0; i < c_nv; i++) begin
                m_vel[i] = 7'd0;
                push_exp(i, 7'd0);
            end
            m_ended = '0;
            pk      = '0;
            ps      = 1'b0;
        end else begin
            for (int i = 0; i < c_nv; i++) begin
                set_v[i] = (m_vel[i] != 7'd0) &&
                           ((pk[i] && !key_held[i] && !sustain) || (ps && !sustain && !key_held[i]));
            end
            for (int i = 0; i < c_nv; i++) begin
                if (note_on[i]) begin
                    m_vel[i]   = note_velocity;
                    m_ended[i] = 1'b0;
                    push_exp(i, note_velocity);
                end else begin
                    if (sw && vi == i) begin
                        g        = env_model(m_vel[i], key_held[i], m_ended[i], pedal_depth);
                        m_vel[i] = (g > m_vel[i]) ? 7'd0 : g;
                        push_exp(i, m_vel[i]);
                    end
                    if (set_v[i]) m_ended[i] = 1'b1;
                    else if (sw && vi == i) m_ended[i] = 1'b0;
                end
            end
            pk = key_held;
            ps = sustain;
        end
        @(negedge clk);
        cyc++;
        note_on = '0;
    endtask

    task automatic run_to(input int t);
        while (cyc - base < t) run_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            at  rst  note_on  nvel   key      sus   chk vce vel  ended
        vecs[0]  = '{ 0, 1'b0, 4'b0000, 7'd0,   4'b0000, 1'b0,  0, 0,   0, -1};
        vecs[1]  = '{12, 1'b0, 4'b0010, 7'd100, 4'b0010, 1'b0, 13, 1, 100, -1};
        vecs[2]  = '{14, 1'b0, 4'b0000, 7'd0,   4'b0010, 1'b0, 18, 1,  99, -1};
        vecs[3]  = '{19, 1'b0, 4'b0000, 7'd0,   4'b0010, 1'b0, 26, 1,  98, -1};
        vecs[4]  = '{27, 1'b0, 4'b0010, 7'd84,  4'b0010, 1'b0, 28, 1,  84, -1};
        vecs[5]  = '{28, 1'b0, 4'b0000, 7'd0,   4'b0000, 1'b0, 34, 1,  69,  1};
        vecs[6]  = '{35, 1'b0, 4'b0000, 7'd0,   4'b0000, 1'b0, 42, 1,  57,  0};
        vecs[7]  = '{43, 1'b0, 4'b0100, 7'd10,  4'b0100, 1'b0, 44, 2,  10, -1};
        vecs[8]  = '{44, 1'b0, 4'b0000, 7'd0,   4'b0000, 1'b0, 51, 2,   0,  1};
        vecs[9]  = '{52, 1'b0, 4'b1000, 7'd31,  4'b1000, 1'b0, 53, 3,  31, -1};
        vecs[10] = '{59, 1'b0, 4'b1000, 7'd50,  4'b1000, 1'b0, 60, 3,  50, -1};
        vecs[11] = '{67, 1'b0, 4'b0000, 7'd0,   4'b0000, 1'b0, 68, 3,  38,  0};
        vecs[12] = '{68, 1'b0, 4'b0000, 7'd0,   4'b0000, 1'b0, 76, 3,  23,  1};
        vecs[13] = '{82, 1'b1, 4'b0000, 7'd0,   4'b0000, 1'b0,  0, 3,   0, -1};
        vecs[14] = '{ 2, 1'b0, 4'b0011, 7'd40,  4'b0011, 1'b1,  3, 0,  40, -1};
        vecs[15] = '{ 3, 1'b0, 4'b0000, 7'd0,   4'b0000, 1'b1,  4, 1,  40, -1};
        vecs[16] = '{ 5, 1'b0, 4'b0000, 7'd0,   4'b0010, 1'b0,  9, 0,  25,  1};
        vecs[17] = '{ 9, 1'b0, 4'b0000, 7'd0,   4'b0010, 1'b0, 10, 1,  39,  0};

        for (int i = 0; i < c_nv; i++) m_vel[i] = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        cyc  = 0;
        base = 0;

        for (int i = 0; i < $size(vecs); i++) begin
            run_to(vecs[i].at);
            if (vecs[i].do_rst) begin
                rst = 1'b1;
                run_cycle();
                rst  = 1'b0;
                base = cyc;
            end else begin
                note_on       = vecs[i].non;
                note_velocity = vecs[i].nvel;
                key_held      = vecs[i].key;
                sustain       = vecs[i].sus;
            end
            if (vecs[i].en_exp >= 0) begin
                run_to(vecs[i].chk_at - 1);
                #1;
                check($sformatf("vec%0d ended_note", i), ended_note, vecs[i].en_exp);
            end
            run_to(vecs[i].chk_at);
            #1;
            check($sformatf("vec%0d voice%0d velocity", i, vecs[i].voice),
                  voice_velocity[7*vecs[i].voice +: 7], vecs[i].exp_vel);
            if (vecs[i].do_rst) begin
                check("post-reset all velocities", voice_velocity, 0);
                check("post-reset envelope_pulse", envelope_pulse, 1'b0);
            end
        end

        run_to(14);
        check("scoreboard drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
